// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a fifo_param instance and its user.
// The user side drives writes, reads, thresholds and the error clear.
interface fifo_param_if #(
    parameter int BITNUMBER = 8,
    parameter int LENGTH    = 8
);
    localparam int AW = $clog2(LENGTH);

    logic [BITNUMBER-1:0] Fifo_Data_in;
    logic                 Fifo_wr;
    logic                 Fifo_rd;
    logic [AW:0]          umbral_alto;
    logic [AW:0]          umbral_bajo;
    logic                 Fifo_err_clr;
    logic [BITNUMBER-1:0] Fifo_Data_out;
    logic                 Fifo_valid;
    logic [AW:0]          Fifo_count;
    logic                 Fifo_full;
    logic                 Fifo_empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 Fifo_wr_error;
    logic                 Fifo_rd_error;
    logic                 Fifo_error;

    modport master (
        output Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo, Fifo_err_clr,
        input  Fifo_Data_out, Fifo_valid, Fifo_count, Fifo_full, Fifo_empty,
               almost_full, almost_empty, Fifo_wr_error, Fifo_rd_error, Fifo_error
    );

    modport slave (
        input  Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo, Fifo_err_clr,
        output Fifo_Data_out, Fifo_valid, Fifo_count, Fifo_full, Fifo_empty,
               almost_full, almost_empty, Fifo_wr_error, Fifo_rd_error, Fifo_error
    );
endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO with registered or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, per-cycle error pulses and a sticky error.
module fifo_param #(
    parameter int BITNUMBER = 8,
    parameter int LENGTH    = 8,
    parameter int FWFT      = 0
) (
    input  logic         clk,
    input  logic         reset,
    fifo_param_if.slave  bus
);
    localparam int AW = $clog2(LENGTH);

    logic [BITNUMBER-1:0] mem [LENGTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          wr_err_q, wr_err_d;
    logic          rd_err_q, rd_err_d;
    logic          err_q, err_d;
    logic          rd_acc, wr_acc;

    always_comb begin
        rd_acc   = bus.Fifo_rd && !empty_q;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_acc   = bus.Fifo_wr && (!full_q || rd_acc);
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(rd_acc);
        count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        full_d   = (count_d == (AW+1)'(LENGTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= bus.umbral_alto);
        aempty_d = (count_d <= bus.umbral_bajo);
        wr_err_d = bus.Fifo_wr && !wr_acc;
        rd_err_d = bus.Fifo_rd && empty_q;
        // A fresh error outranks a clear on the same edge.
        if (wr_err_d || rd_err_d) begin
            err_d = 1'b1;
        end else if (bus.Fifo_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.Fifo_Data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [BITNUMBER-1:0] dout_q, dout_d;
            logic                 valid_q, valid_d;

            always_comb begin
                dout_d  = dout_q;
                valid_d = rd_acc;
                if (rd_acc) begin
                    dout_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= dout_d;
                    valid_q <= valid_d;
                end
            end

            assign bus.Fifo_Data_out = dout_q;
            assign bus.Fifo_valid    = valid_q;
        end else begin : g_fwft_read
            // Head word is shown directly; reset masks the unreset memory behind it.
            assign bus.Fifo_Data_out = reset ? '0 : mem[rd_ptr_q];
            assign bus.Fifo_valid    = !empty_q;
        end
    endgenerate

    assign bus.Fifo_count    = count_q;
    assign bus.Fifo_full     = full_q;
    assign bus.Fifo_empty    = empty_q;
    assign bus.almost_full   = afull_q;
    assign bus.almost_empty  = aempty_q;
    assign bus.Fifo_wr_error = wr_err_q;
    assign bus.Fifo_rd_error = rd_err_q;
    assign bus.Fifo_error    = err_q;
endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter BITNUMBER, default 8, SHALL set the data word width.
REQ-002 Parameter LENGTH, default 8, SHALL set the depth in words; it SHALL be a power of two, 2 or more. Define AW = log2(LENGTH).
REQ-003 Parameter FWFT, default 0, SHALL select the read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 Fifo_Data_in  input  BITNUMBER  SHALL carry the write data.
REQ-007 Fifo_wr  input  1  SHALL be the write request.
REQ-008 Fifo_rd  input  1  SHALL be the read request.
REQ-009 umbral_alto  input  AW+1  SHALL set the almost-full threshold.
REQ-010 umbral_bajo  input  AW+1  SHALL set the almost-empty threshold.
REQ-011 Fifo_err_clr  input  1  SHALL clear the sticky error.
REQ-012 Fifo_Data_out  output  BITNUMBER  SHALL carry the read data.
REQ-013 Fifo_valid  output  1  SHALL mark Fifo_Data_out as valid.
REQ-014 Fifo_count  output  AW+1  SHALL give the number of stored words, 0..LENGTH.
REQ-015 Fifo_full, Fifo_empty, almost_full, almost_empty  output  1 each  SHALL be the status flags.
REQ-016 Fifo_wr_error, Fifo_rd_error  output  1 each  SHALL be per-cycle error pulses.
REQ-017 Fifo_error  output  1  SHALL be the sticky error flag.

Function
REQ-018 Storage SHALL be an internal LENGTH x BITNUMBER array with wr_ptr and rd_ptr of AW bits, each wrapping LENGTH-1 -> 0 by natural overflow.
REQ-019 rd_acc SHALL equal Fifo_rd && !Fifo_empty.
REQ-020 wr_acc SHALL equal Fifo_wr && (!Fifo_full || rd_acc), so a write to a full FIFO with a same-cycle accepted read succeeds.
REQ-021 On wr_acc, the block SHALL write mem[wr_ptr] <= Fifo_Data_in and increment wr_ptr.
REQ-022 On rd_acc, the block SHALL increment rd_ptr.
REQ-023 Fifo_count SHALL update to count + wr_acc - rd_acc; simultaneous accepted read and write SHALL leave the count unchanged.
REQ-024 All flags SHALL be registered and computed from the next count, so they are coherent with Fifo_count in the same cycle.
REQ-025 Fifo_full SHALL be 1 when count == LENGTH; Fifo_empty SHALL be 1 when count == 0.
REQ-026 almost_full SHALL be 1 when count >= umbral_alto; almost_empty SHALL be 1 when count <= umbral_bajo; thresholds are sampled every cycle.
REQ-027 FWFT=0: on rd_acc, Fifo_Data_out SHALL load mem[rd_ptr] at that edge, and Fifo_valid SHALL be 1 for exactly the following cycle (1-cycle latency).
REQ-028 FWFT=0: when there is no rd_acc, Fifo_Data_out SHALL hold its last value.
REQ-029 FWFT=1: Fifo_Data_out SHALL equal mem[rd_ptr] and Fifo_valid SHALL equal !Fifo_empty; Fifo_rd acts as the acknowledge.
REQ-030 FWFT=1: the first word written into an empty FIFO SHALL appear on Fifo_Data_out one cycle after the write edge.
REQ-031 Fifo_wr_error SHALL be 1 for one cycle after any edge where Fifo_wr && !wr_acc.
REQ-032 Fifo_rd_error SHALL be 1 for one cycle after any edge where Fifo_rd && Fifo_empty.
REQ-033 A rejected request SHALL change no pointer, no count and no memory content.
REQ-034 Fifo_error SHALL set on any edge where a write or read error occurs, and SHALL hold until an edge with Fifo_err_clr=1 and no new error.
REQ-035 When a new error and Fifo_err_clr occur on the same edge, set SHALL win.

Reset
REQ-036 While reset=1, the block SHALL force immediately, independent of clk: pointers 0, Fifo_count 0, Fifo_empty 1, Fifo_full 0, almost_empty 1, almost_full 0, Fifo_valid 0, Fifo_Data_out 0, all error outputs 0.
REQ-037 Memory contents SHALL NOT be reset.
REQ-038 Reset asserted mid-burst SHALL discard all stored words.

Verification (BITNUMBER=8, LENGTH=8)
REQ-039 FWFT=0: write 0x11..0x88, then read 8 -> count 8 with full=1 after the writes; data 0x11..0x88 in order, each with valid one cycle after its read; empty=1 at the end.
REQ-040 Full with wr=1, rd=0 -> Fifo_wr_error pulses once, Fifo_error stays 1, count stays 8; then wr+rd together -> write accepted, count stays 8.
REQ-041 Empty with rd=1 -> Fifo_rd_error pulses; Fifo_err_clr=1 next cycle -> Fifo_error 0; error and clear on the same cycle -> Fifo_error 1.
REQ-042 umbral_alto=6, umbral_bajo=2, fill 0->8 -> almost_empty 1 for counts 0..2, almost_full 1 for counts 6..8, both coherent with Fifo_count.
REQ-043 FWFT=1: write 0xA5 into empty -> next cycle Fifo_Data_out=0xA5, valid=1; rd=1 -> empty=1, valid=0.
REQ-044 Write 5 words, assert reset between clock edges -> outputs take reset values immediately; after release, rd -> Fifo_rd_error=1.
